// File: rtl/counter_pkg.sv
// Shared types for the parametrised up/down counter.
package counter_pkg;

  // Mode encoding of the two-bit sw input.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_UP   = 2'b01,
    CNT_DOWN = 2'b10,
    CNT_LOAD = 2'b11
  } cnt_mode_e;

endpackage

// File: rtl/counter_step.sv
// Combinational next-count logic: computes the successor of the current count
// for the requested mode, plus boundary and overflow/underflow indications.
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count,
  input  cnt_mode_e        mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             bnd_flag,
  output logic             ovf_set,
  output logic             unf_set
);

  // One extra bit keeps sums and the modulus free of truncation.
  localparam logic [WIDTH:0] MAX_EXT  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] sum_up;
  logic [WIDTH:0] up_wrap;
  logic [WIDTH:0] diff_dn;
  logic [WIDTH:0] dn_wrap;

  assign cnt_ext  = {1'b0, count};
  assign load_ext = {1'b0, load_val};
  assign sum_up   = cnt_ext + STEP_EXT;
  assign up_wrap  = sum_up - MOD_EXT;
  assign diff_dn  = cnt_ext - STEP_EXT;
  assign dn_wrap  = cnt_ext + MOD_EXT - STEP_EXT;

  // Select the successor value and event flags for the current mode.
  always_comb begin
    next_count = count;
    bnd_flag   = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    case (mode)
      CNT_UP: begin
        if (sum_up <= MAX_EXT) begin
          next_count = sum_up[WIDTH-1:0];
        end else begin
          next_count = (SATURATE != 0) ? MAX_EXT[WIDTH-1:0] : up_wrap[WIDTH-1:0];
          bnd_flag   = 1'b1;
          ovf_set    = 1'b1;
        end
      end
      CNT_DOWN: begin
        if (cnt_ext >= STEP_EXT) begin
          next_count = diff_dn[WIDTH-1:0];
        end else begin
          next_count = (SATURATE != 0) ? '0 : dn_wrap[WIDTH-1:0];
          bnd_flag   = 1'b1;
          unf_set    = 1'b1;
        end
      end
      CNT_LOAD: begin
        if (load_ext > MAX_EXT) begin
          next_count = MAX_EXT[WIDTH-1:0];
          bnd_flag   = 1'b1;
        end else begin
          next_count = load_val;
        end
      end
      default: begin
        next_count = count;
      end
    endcase
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down LED counter with hold, load, enable, boundary pulse
// and sticky overflow/underflow flags. All state changes on clkpulse rising edge.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic             clkpulse,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       sw,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             at_max,
  output logic             at_min,
  output logic             bnd,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  // Reject parameter sets that would let the count leave its range.
  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_bad_max
    $error("updown_counter_mod: MAX_VAL out of range 1..2**WIDTH-1");
  end
  if (STEP < 1 || STEP > MAX_VAL) begin : g_bad_step
    $error("updown_counter_mod: STEP out of range 1..MAX_VAL");
  end

  cnt_mode_e        mode;
  logic [WIDTH-1:0] next_count;
  logic             bnd_flag;
  logic             ovf_set;
  logic             unf_set;

  assign mode = cnt_mode_e'(sw);

  counter_step #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .STEP     (STEP),
    .SATURATE (SATURATE)
  ) u_step (
    .count      (led),
    .mode       (mode),
    .load_val   (load_val),
    .next_count (next_count),
    .bnd_flag   (bnd_flag),
    .ovf_set    (ovf_set),
    .unf_set    (unf_set)
  );

  // Count register and flags: reset wins, then enable/hold, then the step result.
  always_ff @(posedge clkpulse) begin
    if (!rst) begin
      led <= '0;
      bnd <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (!en || mode == CNT_HOLD) begin
      bnd <= 1'b0;
    end else begin
      led <= next_count;
      bnd <= bnd_flag;
      if (mode == CNT_LOAD) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        if (ovf_set) ovf <= 1'b1;
        if (unf_set) unf <= 1'b1;
      end
    end
  end

  assign at_max = (led == MAX_W);
  assign at_min = (led == '0);

endmodule
